// File: rtl/fpu_normalize_round_if.sv
// rtl/fpu_normalize_round_if.sv - request/result bundle for the normalize-and-round stage
interface fpu_normalize_round_if;
  logic        start;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        flag_zero;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inexact;

  modport master (
    output start, in_sign, in_exp, in_mant,
    input  busy, done, result, flag_zero, flag_ovf, flag_unf, flag_inexact
  );

  modport slave (
    input  start, in_sign, in_exp, in_mant,
    output busy, done, result, flag_zero, flag_ovf, flag_unf, flag_inexact
  );
endinterface

// File: rtl/fpu_normalize_round.sv
// rtl/fpu_normalize_round.sv - iterative normalize, round-to-nearest-even and pack to single precision
module fpu_normalize_round (
  input  logic                  clk,
  input  logic                  arst,
  fpu_normalize_round_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] PACK  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               sign_q, sign_d;
  // One spare bit so a carry shift plus a rounding carry from 510 cannot wrap.
  logic signed [10:0] exp_q, exp_d;
  logic [27:0]        mant_q, mant_d;
  logic               zero_q, zero_d;
  logic               grs_q, grs_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic               fz_q, fz_d;
  logic               fo_q, fo_d;
  logic               fu_q, fu_d;
  logic               fi_q, fi_d;

  logic [27:0]        rnd_sum;
  logic               rnd_inc;

  assign rnd_sum = mant_q + 28'd8;
  assign rnd_inc = mant_q[2] & (mant_q[3] | mant_q[1] | mant_q[0]);

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    zero_d   = zero_q;
    grs_d    = grs_q;
    done_d   = 1'b0;
    result_d = result_q;
    fz_d     = fz_q;
    fo_d     = fo_q;
    fu_d     = fu_q;
    fi_d     = fi_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d  = bus.in_sign;
          exp_d   = {bus.in_exp[9], bus.in_exp};
          mant_d  = bus.in_mant;
          zero_d  = 1'b0;
          grs_d   = 1'b0;
          fz_d    = 1'b0;
          fo_d    = 1'b0;
          fu_d    = 1'b0;
          fi_d    = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mant_q == 28'd0) begin
          zero_d  = 1'b1;
          state_d = PACK;
        end else if (mant_q[27]) begin
          mant_d  = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + 11'sd1;
          state_d = ROUND;
        end else if (!mant_q[26]) begin
          mant_d  = {mant_q[26:0], 1'b0};
          exp_d   = exp_q - 11'sd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        grs_d = |mant_q[2:0];
        if (rnd_inc) begin
          if (rnd_sum[27]) begin
            mant_d = {1'b0, rnd_sum[27:1]};
            exp_d  = exp_q + 11'sd1;
          end else begin
            mant_d = rnd_sum;
          end
        end
        state_d = PACK;
      end
      default: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_q) begin
          result_d = {sign_q, 31'd0};
          fz_d     = 1'b1;
        end else if (exp_q >= 11'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          fo_d     = 1'b1;
          fi_d     = 1'b1;
        end else if (exp_q <= 11'sd0) begin
          result_d = {sign_q, 31'd0};
          fu_d     = 1'b1;
          fi_d     = 1'b1;
        end else begin
          result_d = {sign_q, exp_q[7:0], mant_q[25:3]};
          fi_d     = grs_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      zero_q   <= 1'b0;
      grs_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      fz_q     <= 1'b0;
      fo_q     <= 1'b0;
      fu_q     <= 1'b0;
      fi_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      zero_q   <= zero_d;
      grs_q    <= grs_d;
      done_q   <= done_d;
      result_q <= result_d;
      fz_q     <= fz_d;
      fo_q     <= fo_d;
      fu_q     <= fu_d;
      fi_q     <= fi_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.flag_zero    = fz_q;
  assign bus.flag_ovf     = fo_q;
  assign bus.flag_unf     = fu_q;
  assign bus.flag_inexact = fi_q;

endmodule
